reg_file_host: RTL and testbench
================================

# reg_file_host

Command-side controller that owns the access port of a `reg_file` instance and serves one transaction at a time to an upstream master over valid/ready request and response channels. It converts each request into the register file's enable/select/data strobes and absorbs the file's one-cycle registered read latency. It range-checks addresses and returns read data or an error on the response channel.

## Interface

- `DATA_WIDTH`, 16, word width; must equal the attached register file's `data_width`.
- `REG_NUMBER`, 8, number of registers; must equal the attached file's `reg_number`.
- Derived: `ADDR_W = $clog2(REG_NUMBER)+1`, the select width of the register file.

Ports:

- `clk`  in  1  the single clock; all state is updated on its rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_W  register index.
- `req_wdata`  in  DATA_WIDTH  write data.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  master accepts the response.
- `rsp_write`  out  1  echo of `req_write` for this transaction.
- `rsp_err`  out  1  address was out of range.
- `rsp_rdata`  out  DATA_WIDTH  read data; 0 for writes and errors.
- `rf_en_w`, `rf_en_r`  out  1  write and read strobes to the register file.
- `rf_select_w`, `rf_select_r`  out  ADDR_W  register file select lines.
- `rf_data_in`  out  DATA_WIDTH  register file write data.
- `rf_data_out`  in  DATA_WIDTH  register file registered read data.

## Operation

- **FSM states:** IDLE, ISSUE, CAPTURE, RESP. All outputs are registered or decoded from state only; there is no combinational path from request inputs to outputs.
- **IDLE:**
  - `req_ready=1`.
  - On `req_valid && req_ready`, latch write, addr, wdata and go to ISSUE.
  - Set `err = (req_addr >= REG_NUMBER)`.
- **ISSUE (exactly one cycle):**
  - `rf_select_w`, `rf_select_r` and `rf_data_in` carry the latched values.
  - Write, in range: `rf_en_w=1`, then go to RESP.
  - Read, in range: `rf_en_r=1`, then go to CAPTURE.
  - Error: no strobe, then go to RESP.
- **CAPTURE (exactly one cycle):**
  - Register `rf_data_out` into `rsp_rdata`.
  - Go to RESP.
- **RESP:**
  - `rsp_valid=1`; `rsp_write`, `rsp_err` and `rsp_rdata` are held stable.
  - On `rsp_ready`, go to IDLE.
- **Strobe rules:** `rf_en_w` and `rf_en_r` are never high together, and never high outside ISSUE.
- **Address and data hold:** select and data lines hold their last latched values between transactions; they are 0 after reset.
- **Out-of-range addresses:** an address in the range REG_NUMBER to 2^ADDR_W-1 never reaches the register file. It produces `rsp_err=1` and `rsp_rdata=0`.
- **Ordering:** one outstanding transaction at a time, and no reordering. A read following a write to the same address returns the written data.

## Timing

- **Reset:** `rst_n` low immediately forces state IDLE and drives every output to 0, except `req_ready`, which goes to 1 once reset is released.
  - Reset mid-transaction discards the transaction; no response is produced.
  - The register file resets synchronously, so `rst_n` must stay low across at least one `clk` edge.
- **Latency, with the request accepted in cycle T:**
  - Write: `rf_en_w` in T+1; `rsp_valid` from T+2.
  - Read: `rf_en_r` in T+1; data captured at the end of T+2; `rsp_valid` from T+3.
  - Error: `rsp_valid` from T+2.
- **Request handshake:** `req_ready` is low from T+1 until the cycle after the response handshake. Minimum back-to-back spacing is 3 cycles for writes and 4 cycles for reads.
- **Backpressure:** while `rsp_valid && !rsp_ready`, all `rsp_*` outputs are frozen. No new request is accepted and no strobe is issued.
- **Request channel:** request inputs are sampled only in the accept cycle; they may change freely at any other time.

## Test plan

- **Reset:** assert `rst_n=0` mid-cycle. All outputs go to 0 asynchronously; after release, `req_ready=1` and `rsp_valid=0`.
- **Write:** write addr 3, data 0xBEEF, accepted in T. In T+1: `rf_en_w=1`, `rf_select_w=3`, `rf_data_in=0xBEEF`. From T+2: `rsp_valid=1`, `rsp_write=1`, `rsp_err=0`, `rsp_rdata=0`.
- **Read-back:** read addr 3 after that write. In T+1: `rf_en_r=1`, `rf_select_r=3`. From T+3: `rsp_valid=1`, `rsp_rdata=0xBEEF`, `rsp_err=0`.
- **Out of range:** read and write addr 8 with `REG_NUMBER=8`. No strobe in any cycle; from T+2: `rsp_err=1`, `rsp_rdata=0`. A subsequent read of addr 0 returns its prior value unchanged.
- **Backpressure:** hold `rsp_ready=0` for 5 cycles with `req_valid` held high for a second write. The response stays stable, `req_ready=0` and no `rf_en_w` occurs. The second request is accepted the cycle after the `rsp_ready` handshake.
- **Reset mid-read:** pulse `rst_n` low during CAPTURE. `rsp_valid` never rises, and the next read transaction completes normally with 4-cycle spacing.

Source files
------------

// File: rtl/reg_file_host.sv
// reg_file_host: single-outstanding command controller in front of a reg_file.
// Turns valid/ready requests into register-file strobes, absorbs the file's
// one-cycle read latency and returns data or an address error on the response
// channel. Every output is a flop or a decode of flops; request inputs only
// feed next-state logic.
module reg_file_host #(
    parameter int DATA_WIDTH = 16,
    parameter int REG_NUMBER = 8,
    localparam int ADDR_W    = $clog2(REG_NUMBER) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // request channel
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    // response channel
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic                  rsp_err,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    // register file access port
    output logic                  rf_en_w,
    output logic                  rf_en_r,
    output logic [ADDR_W-1:0]     rf_select_w,
    output logic [ADDR_W-1:0]     rf_select_r,
    output logic [DATA_WIDTH-1:0] rf_data_in,
    input  logic [DATA_WIDTH-1:0] rf_data_out
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_RESP    = 2'd3;

    localparam logic [ADDR_W-1:0] REG_LAST = ADDR_W'(REG_NUMBER - 1);

    logic [1:0]            state_q, state_d;
    logic                  ready_q, ready_d;
    logic                  wr_q, wr_d;
    logic                  err_q, err_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  req_oor;

    assign req_oor = (req_addr > REG_LAST);

    // Next-state, request latching and read-data capture.
    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid && ready_q) begin
                    wr_d    = req_write;
                    err_d   = req_oor;
                    rdata_d = '0;
                    // Out-of-range requests leave the select/data lines on
                    // their previous values so a bad index never shows up
                    // on the register file port.
                    if (!req_oor) begin
                        addr_d  = req_addr;
                        wdata_d = req_wdata;
                    end
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = (!wr_q && !err_q) ? S_CAPTURE : S_RESP;
            end
            S_CAPTURE: begin
                rdata_d = rf_data_out;
                state_d = S_RESP;
            end
            default: begin
                if (rsp_ready) state_d = S_IDLE;
            end
        endcase
        // Registered so req_ready stays low while reset is held and rises
        // on the first edge after release.
        ready_d = (state_d == S_IDLE);
    end

    // State and datapath registers; reset clears everything to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ready_q <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign req_ready   = ready_q;
    assign rsp_valid   = (state_q == S_RESP);
    assign rsp_write   = wr_q;
    assign rsp_err     = err_q;
    assign rsp_rdata   = rdata_q;
    // Strobes only in ISSUE, and write/read are mutually exclusive via wr_q.
    assign rf_en_w     = (state_q == S_ISSUE) && wr_q && !err_q;
    assign rf_en_r     = (state_q == S_ISSUE) && !wr_q && !err_q;
    assign rf_select_w = addr_q;
    assign rf_select_r = addr_q;
    assign rf_data_in  = wdata_q;

endmodule

// File: tb/tb_reg_file_host.sv
// Directed bench for reg_file_host with a behavioural reg_file attached
// (synchronous reset, one-cycle registered read).
module tb_reg_file_host;

    localparam int DW = 16;
    localparam int RN = 8;
    localparam int AW = $clog2(RN) + 1;

    logic          clk;
    logic          rst_n;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_ready, rsp_write, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic          rf_en_w, rf_en_r;
    logic [AW-1:0] rf_select_w, rf_select_r;
    logic [DW-1:0] rf_data_in, rf_data_out;

    int n_tests = 0;
    int n_fail  = 0;

    reg_file_host #(.DATA_WIDTH(DW), .REG_NUMBER(RN)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .rf_en_w(rf_en_w), .rf_en_r(rf_en_r),
        .rf_select_w(rf_select_w), .rf_select_r(rf_select_r),
        .rf_data_in(rf_data_in), .rf_data_out(rf_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural register file
    logic [DW-1:0] rf_mem [RN];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < RN; i++) rf_mem[i] <= '0;
            rf_data_out <= '0;
        end else begin
            if (rf_en_w && rf_select_w < AW'(RN)) rf_mem[rf_select_w[AW-2:0]] <= rf_data_in;
            if (rf_en_r && rf_select_r < AW'(RN)) rf_data_out <= rf_mem[rf_select_r[AW-2:0]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // advance to 1ns after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rdy"},   32'(req_ready),   0);
        chk({tag, "_vld"},   32'(rsp_valid),   0);
        chk({tag, "_wr"},    32'(rsp_write),   0);
        chk({tag, "_err"},   32'(rsp_err),     0);
        chk({tag, "_rdata"}, 32'(rsp_rdata),   0);
        chk({tag, "_enw"},   32'(rf_en_w),     0);
        chk({tag, "_enr"},   32'(rf_en_r),     0);
        chk({tag, "_selw"},  32'(rf_select_w), 0);
        chk({tag, "_selr"},  32'(rf_select_r), 0);
        chk({tag, "_din"},   32'(rf_data_in),  0);
    endtask

    // One full transaction: accept in T, check every cycle to the handshake.
    task automatic txn(input string tag, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic exp_err, input logic [DW-1:0] exp_rd);
        chk({tag, "_rdyT"}, 32'(req_ready), 1);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        step();                                   // T+1: ISSUE
        req_valid = 1'b0; req_write = ~w; req_addr = 4'hF; req_wdata = 16'h5A5A;
        chk({tag, "_enw"}, 32'(rf_en_w), 32'(w && !exp_err));
        chk({tag, "_enr"}, 32'(rf_en_r), 32'(!w && !exp_err));
        chk({tag, "_rdy1"}, 32'(req_ready), 0);
        chk({tag, "_vld1"}, 32'(rsp_valid), 0);
        if (!exp_err) begin
            if (w) begin
                chk({tag, "_selw"}, 32'(rf_select_w), 32'(a));
                chk({tag, "_din"},  32'(rf_data_in),  32'(d));
            end else begin
                chk({tag, "_selr"}, 32'(rf_select_r), 32'(a));
            end
        end
        if (!w && !exp_err) begin
            step();                               // T+2: CAPTURE
            chk({tag, "_vld2"}, 32'(rsp_valid), 0);
            chk({tag, "_en2"},  32'({rf_en_w, rf_en_r}), 0);
        end
        step();                                   // first RESP cycle
        chk({tag, "_vld"},   32'(rsp_valid), 1);
        chk({tag, "_rwr"},   32'(rsp_write), 32'(w));
        chk({tag, "_rerr"},  32'(rsp_err),   32'(exp_err));
        chk({tag, "_rdata"}, 32'(rsp_rdata), 32'(exp_rd));
        chk({tag, "_enR"},   32'({rf_en_w, rf_en_r}), 0);
        rsp_ready = 1'b1;
        step();                                   // back in IDLE
        rsp_ready = 1'b0;
        chk({tag, "_rdyE"}, 32'(req_ready), 1);
        chk({tag, "_vldE"}, 32'(rsp_valid), 0);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
        step(); step();
        chk_all_zero("rst");
        #2 rst_n = 1'b1;
        step();
        chk("rel_rdy", 32'(req_ready), 1);
        chk("rel_vld", 32'(rsp_valid), 0);

        // reset asserted mid-cycle while a response is pending
        req_valid = 1'b1; req_write = 1'b1; req_addr = 5; req_wdata = 16'h1234;
        step(); req_valid = 1'b0;
        step();
        chk("pre_rst_vld", 32'(rsp_valid), 1);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_rst");
        step();
        #2 rst_n = 1'b1;
        step();
        chk("rel2_rdy", 32'(req_ready), 1);

        // write / read-back / in-range boundary
        txn("wr3", 1'b1, 3, 16'hBEEF, 1'b0, 16'h0000);
        txn("rd3", 1'b0, 3, 16'h0000, 1'b0, 16'hBEEF);
        txn("wr0", 1'b1, 0, 16'h1234, 1'b0, 16'h0000);
        txn("wr7", 1'b1, 7, 16'hA5A5, 1'b0, 16'h0000);
        txn("rd7", 1'b0, 7, 16'h0000, 1'b0, 16'hA5A5);

        // out of range
        txn("rd8",  1'b0, 8,  16'h0000, 1'b1, 16'h0000);
        txn("wr8",  1'b1, 8,  16'hDEAD, 1'b1, 16'h0000);
        txn("rd15", 1'b0, 15, 16'h0000, 1'b1, 16'h0000);
        txn("rd0",  1'b0, 0,  16'h0000, 1'b0, 16'h1234);

        // backpressure with a second write waiting
        req_valid = 1'b1; req_write = 1'b1; req_addr = 1; req_wdata = 16'h1111;
        step();                                   // T+1
        chk("bp_enw1", 32'(rf_en_w), 1);
        req_addr = 2; req_wdata = 16'h2222;
        step();                                   // T+2
        for (int i = 0; i < 5; i++) begin
            chk("bp_vld",   32'(rsp_valid), 1);
            chk("bp_rwr",   32'(rsp_write), 1);
            chk("bp_rerr",  32'(rsp_err),   0);
            chk("bp_rdata", 32'(rsp_rdata), 0);
            chk("bp_rdy",   32'(req_ready), 0);
            chk("bp_enw",   32'(rf_en_w),   0);
            if (i < 4) step();
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("bp_rdy_after", 32'(req_ready), 1);
        chk("bp_vld_after", 32'(rsp_valid), 0);
        step();                                   // second write in ISSUE
        req_valid = 1'b0;
        chk("bp2_enw",  32'(rf_en_w),     1);
        chk("bp2_selw", 32'(rf_select_w), 2);
        chk("bp2_din",  32'(rf_data_in),  32'h2222);
        step();
        chk("bp2_vld", 32'(rsp_valid), 1);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        txn("rd1", 1'b0, 1, 16'h0000, 1'b0, 16'h1111);
        txn("rd2", 1'b0, 2, 16'h0000, 1'b0, 16'h2222);

        // reset during CAPTURE of a read
        req_valid = 1'b1; req_write = 1'b0; req_addr = 2;
        step(); req_valid = 1'b0;                 // ISSUE
        step();                                   // CAPTURE
        #2 rst_n = 1'b0;
        #1 chk_all_zero("cap_rst");
        step();
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("cap_rst_novld", 32'(rsp_valid), 0);
        end
        // register file was reset as well, so addr 2 now reads 0
        txn("rd2_post", 1'b0, 2, 16'h0000, 1'b0, 16'h0000);
        txn("wr4_post", 1'b1, 4, 16'hC0DE, 1'b0, 16'h0000);
        txn("rd4_post", 1'b0, 4, 16'h0000, 1'b0, 16'hC0DE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // strobes must never be high together
    always @(negedge clk) begin
        if (rst_n && rf_en_w && rf_en_r) begin
            n_tests++;
            n_fail++;
            $display("FAIL strobe_excl: got en_w=1 en_r=1 expected at most one");
        end
    end

endmodule
